board_video_adapter: RTL and testbench

//  Converts guest core RGB/sync to the board VGA pins, generalised over colour widths.

---
 rtl/board_video_pkg.sv | 16 +
 rtl/board_video_adapter_sync_polarity_detect.sv | 73 +++++++
 rtl/board_video_adapter.sv | 152 +++++++++++++++
 tb/tb_board_video_adapter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/board_video_pkg.sv
// rtl/board_video_pkg.sv - shared constants, sync mode type and saturating increment for the VGA adapter
package board_video_pkg;

    typedef enum logic {
        SYNC_PASS = 1'b0,
        SYNC_NEG  = 1'b1
    } sync_mode_t;

    // 2x2 ordered-dither thresholds, indexed by {row, column}
    localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/board_video_adapter_sync_polarity_detect.sv
// rtl/board_video_adapter_sync_polarity_detect.sv - learns sync polarity from full high/low phase lengths
module sync_polarity_detect
    import board_video_pkg::*;
#(
    parameter int CNT_BITS = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic sync,
    output logic pol
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_BITS) - 64'd1);

    logic                r_primed;
    logic                r_prev;
    logic                r_seen_rise;
    logic                r_seen_fall;
    logic                r_hi_ok;
    logic                r_pol;
    logic [CNT_BITS-1:0] r_cnt_hi;
    logic [CNT_BITS-1:0] r_cnt_lo;
    logic [CNT_BITS-1:0] r_hi_len;
    logic                w_rise;
    logic                w_fall;

    // The first sample after reset only primes r_prev; it is never treated as an edge.
    assign w_rise = r_primed &&  sync && !r_prev;
    assign w_fall = r_primed && !sync &&  r_prev;
    assign pol    = r_pol;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_primed    <= 1'b0;
            r_prev      <= 1'b0;
            r_seen_rise <= 1'b0;
            r_seen_fall <= 1'b0;
            r_hi_ok     <= 1'b0;
            r_pol       <= 1'b0;
            r_cnt_hi    <= '0;
            r_cnt_lo    <= '0;
            r_hi_len    <= '0;
        end else if (ce) begin
            r_primed <= 1'b1;
            r_prev   <= sync;
            if (w_rise) begin
                r_seen_rise <= 1'b1;
                r_cnt_hi    <= '0;
                // A low phase is full only if it began at a falling edge.
                if (r_seen_fall && r_hi_ok) begin
                    if (r_hi_len < r_cnt_lo) begin
                        r_pol <= 1'b1;
                    end else if (r_hi_len > r_cnt_lo) begin
                        r_pol <= 1'b0;
                    end
                end
            end else if (w_fall) begin
                r_seen_fall <= 1'b1;
                r_cnt_lo    <= '0;
                if (r_seen_rise) begin
                    r_hi_len <= r_cnt_hi;
                    r_hi_ok  <= 1'b1;
                end
            end else if (sync) begin
                r_cnt_hi <= CNT_BITS'(sat_inc(32'(r_cnt_hi), CNT_MAX));
            end else begin
                r_cnt_lo <= CNT_BITS'(sat_inc(32'(r_cnt_lo), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/board_video_adapter.sv
// rtl/board_video_adapter.sv - guest RGB/sync to board VGA pins; BOARD_VIDEO_DITHER_EN enables 2x2 dithering
module board_video_adapter
    import board_video_pkg::*;
#(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 6,
    parameter int HS_CNT_BITS = 12,
    parameter int VS_CNT_BITS = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pix_ce,
    input  logic [IN_BITS-1:0]  in_r,
    input  logic [IN_BITS-1:0]  in_g,
    input  logic [IN_BITS-1:0]  in_b,
    input  logic                in_hs,
    input  logic                in_vs,
    input  logic                in_blank,
    input  logic                out_neg,
    output logic [OUT_BITS-1:0] vga_r,
    output logic [OUT_BITS-1:0] vga_g,
    output logic [OUT_BITS-1:0] vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                hs_pol,
    output logic                vs_pol
);

`ifdef BOARD_VIDEO_DITHER_EN
    localparam bit DITHER_EN = 1'b1;
`else
    localparam bit DITHER_EN = 1'b0;
`endif

    logic [IN_BITS-1:0]  w_in   [3];
    logic [IN_BITS-1:0]  r_in1  [3];
    logic [OUT_BITS-1:0] w_cv   [3];
    logic [OUT_BITS-1:0] r_out  [3];
    logic                r_hs1;
    logic                r_vs1;
    logic                r_blank1;
    logic                r_x;
    logic                r_y;
    logic                r_frame;
    logic                r_vga_hs;
    logic                r_vga_vs;
    logic                w_hs_pol;
    logic                w_vs_pol;
    logic                w_hs_edge;
    logic                w_vs_edge;
    logic [1:0]          w_bayer;
    sync_mode_t          w_mode;

    assign w_in[0] = in_r;
    assign w_in[1] = in_g;
    assign w_in[2] = in_b;
    assign w_mode  = sync_mode_t'(out_neg);

    sync_polarity_detect #(.CNT_BITS(HS_CNT_BITS)) u_hs_det (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (pix_ce),
        .sync    (in_hs),
        .pol     (w_hs_pol)
    );

    sync_polarity_detect #(.CNT_BITS(VS_CNT_BITS)) u_vs_det (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (pix_ce),
        .sync    (in_vs),
        .pol     (w_vs_pol)
    );

    // Active edge: the sample entering stage 1 reaches the active level the stage-1 sample lacked.
    assign w_hs_edge = (in_hs == w_hs_pol) && (r_hs1 != w_hs_pol);
    assign w_vs_edge = (in_vs == w_vs_pol) && (r_vs1 != w_vs_pol);
    assign w_bayer   = BAYER[{r_y ^ r_frame, r_x}];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_in1[i] <= '0;
            end
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_blank1 <= 1'b0;
            r_x      <= 1'b0;
            r_y      <= 1'b0;
            r_frame  <= 1'b0;
        end else if (pix_ce) begin
            for (int i = 0; i < 3; i++) begin
                r_in1[i] <= w_in[i];
            end
            r_hs1    <= in_hs;
            r_vs1    <= in_vs;
            r_blank1 <= in_blank;
            r_x      <= w_hs_edge ? 1'b0 : ~r_x;
            if (w_vs_edge) begin
                r_y     <= 1'b0;
                r_frame <= ~r_frame;
            end else if (w_hs_edge) begin
                r_y <= ~r_y;
            end
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        if (IN_BITS > OUT_BITS) begin : g_reduce
            localparam int R = IN_BITS - OUT_BITS;
            logic [OUT_BITS-1:0] w_d;
            logic [1:0]          w_f;
            assign w_d = r_in1[ch][IN_BITS-1 -: OUT_BITS];
            if (R >= 2) begin : g_f2
                assign w_f = r_in1[ch][R-1 -: 2];
            end else begin : g_f1
                assign w_f = {r_in1[ch][0], 1'b0};
            end
            // Saturate at full scale rather than wrap to black.
            assign w_cv[ch] = (DITHER_EN && (w_f > w_bayer) && (w_d != '1)) ? w_d + 1'b1 : w_d;
        end else begin : g_expand
            for (genvar i = 0; i < OUT_BITS; i++) begin : g_bit
                assign w_cv[ch][OUT_BITS-1-i] = r_in1[ch][IN_BITS-1-(i % IN_BITS)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_out[i] <= '0;
            end
            r_vga_hs <= 1'b0;
            r_vga_vs <= 1'b0;
        end else if (pix_ce) begin
            for (int i = 0; i < 3; i++) begin
                r_out[i] <= r_blank1 ? '0 : w_cv[i];
            end
            r_vga_hs <= (w_mode == SYNC_NEG) ? (r_hs1 ^ w_hs_pol) : r_hs1;
            r_vga_vs <= (w_mode == SYNC_NEG) ? (r_vs1 ^ w_vs_pol) : r_vs1;
        end
    end

    assign vga_r  = r_out[0];
    assign vga_g  = r_out[1];
    assign vga_b  = r_out[2];
    assign vga_hs = r_vga_hs;
    assign vga_vs = r_vga_vs;
    assign hs_pol = w_hs_pol;
    assign vs_pol = w_vs_pol;

endmodule

// File: tb/tb_board_video_adapter.sv
// tb/tb_board_video_adapter.sv - randomized self-checking bench for board_video_adapter against a phase-length model
module tb_board_video_adapter;

`ifdef BOARD_VIDEO_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic       in_hs = 1'b0, in_vs = 1'b0, in_blank = 1'b0, out_neg = 1'b0;
    logic [5:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, hs_pol, vs_pol;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    board_video_adapter #(
        .IN_BITS(8), .OUT_BITS(6), .HS_CNT_BITS(12), .VS_CNT_BITS(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_blank(in_blank), .out_neg(out_neg),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .hs_pol(hs_pol), .vs_pol(vs_pol)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state: pixel position, per-sync run lengths and learned polarity.
    int          m_x, m_y, m_fr;
    bit          m_ph, m_pv;
    bit          pm_primed [2], pm_level [2], pm_run_full [2], pm_full_hi [2], pm_pol [2];
    int          pm_run [2], pm_hi_len [2];
    int          bayer_tb [4] = '{0, 2, 3, 1};
    logic [19:0] exp_vid_prev;
    logic [31:0] cur_exp;

    function automatic logic [31:0] dut_vec();
        return {10'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, hs_pol, vs_pol};
    endfunction

    function automatic logic [5:0] conv(input logic [7:0] c);
        int d, f, b;
        d = int'(c) / 4;
        f = int'(c) % 4;
        b = bayer_tb[(((m_y ^ m_fr) & 1) * 2) + m_x];
        if (DITHER && f > b && d != 63) d = d + 1;
        return 6'(d);
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_fr = 0; m_ph = 0; m_pv = 0;
        for (int k = 0; k < 2; k++) begin
            pm_primed[k] = 0; pm_level[k] = 0; pm_run_full[k] = 0;
            pm_full_hi[k] = 0; pm_pol[k] = 0; pm_run[k] = 0; pm_hi_len[k] = 0;
        end
        exp_vid_prev = '0;
        cur_exp      = '0;
    endtask

    // Polarity from completed phase lengths: a short high pulse means active-high.
    task automatic pm_step(input int k, input bit s);
        if (!pm_primed[k]) begin
            pm_primed[k] = 1; pm_level[k] = s; pm_run[k] = 1; pm_run_full[k] = 0;
        end else if (s == pm_level[k]) begin
            pm_run[k]++;
        end else begin
            if (pm_level[k]) begin
                if (pm_run_full[k]) begin
                    pm_hi_len[k] = pm_run[k]; pm_full_hi[k] = 1;
                end
            end else if (pm_run_full[k] && pm_full_hi[k]) begin
                if (pm_hi_len[k] < pm_run[k]) pm_pol[k] = 1;
                else if (pm_hi_len[k] > pm_run[k]) pm_pol[k] = 0;
            end
            pm_level[k] = s; pm_run[k] = 1; pm_run_full[k] = 1;
        end
    endtask

    task automatic idle(input int n);
        pix_ce = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            in_hs = 1'($urandom); in_vs = 1'($urandom); in_blank = 1'($urandom);
            @(posedge clk); #1;
            chk("hold", dut_vec(), cur_exp);
        end
    endtask

    task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input bit hs, input bit vs, input bit blank, input string tag);
        bit          phs, pvs, he, ve;
        logic [19:0] vid;
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        phs = pm_pol[0];
        pvs = pm_pol[1];
        he  = (hs == phs) && (m_ph != phs);
        ve  = (vs == pvs) && (m_pv != pvs);
        if (ve) begin m_y = 0; m_fr ^= 1; end
        else if (he) m_y ^= 1;
        m_x = he ? 0 : (m_x ^ 1);
        pm_step(0, hs);
        pm_step(1, vs);
        vid = {blank ? 6'd0 : conv(r), blank ? 6'd0 : conv(g), blank ? 6'd0 : conv(b),
               out_neg ? (hs ^ pm_pol[0]) : hs, out_neg ? (vs ^ pm_pol[1]) : vs};
        m_ph = hs;
        m_pv = vs;
        in_r = r; in_g = g; in_b = b; in_hs = hs; in_vs = vs; in_blank = blank;
        pix_ce = 1'b1;
        @(posedge clk); #1;
        cur_exp = {10'd0, exp_vid_prev, pm_pol[0], pm_pol[1]};
        chk(tag, dut_vec(), cur_exp);
        exp_vid_prev = vid;
    endtask

    task automatic do_reset(input bit neg);
        pix_ce  = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_state", dut_vec(), 32'd0);
        out_neg = neg;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rnd_px(input bit hs, input bit vs, input string tag);
        px(8'($urandom), 8'($urandom), 8'($urandom), hs, vs, ($urandom_range(0, 7) == 0), tag);
    endtask

    initial begin
        model_reset();
        #2;

        // Depth reduction and two-cycle latency
        do_reset(1'b0);
        px(8'hFF, 8'hFF, 8'hFF, 1, 1, 0, "lat_ff");
        px(8'h83, 8'h83, 8'h83, 1, 1, 0, "lat_83");
        chk("ff_to_3f", 32'(vga_r), 32'h3F);
        px(8'h00, 8'h00, 8'h00, 1, 1, 0, "lat_00");
        px(8'h00, 8'h00, 8'h00, 1, 1, 0, "lat_00b");

        // Polarity learning, active-high 96-cycle pulse, normalised to active-low
        do_reset(1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 96; i++)  rnd_px(1, 1, "pol_hi_pulse");
            for (int i = 0; i < 704; i++) rnd_px(0, 1, "pol_hi_line");
        end
        chk("hs_pol_early", 32'(hs_pol), 32'd0);
        for (int i = 0; i < 50; i++) rnd_px(1, 1, "pol_hi_pulse");
        chk("hs_pol_hi", 32'(hs_pol), 32'd1);
        chk("vga_hs_pulse_hi", 32'(vga_hs), 32'd0);
        for (int i = 50; i < 96; i++) rnd_px(1, 1, "pol_hi_pulse");
        for (int i = 0; i < 352; i++) rnd_px(0, 1, "pol_hi_line");
        chk("vga_hs_line_hi", 32'(vga_hs), 32'd1);
        for (int i = 352; i < 704; i++) rnd_px(0, 1, "pol_hi_line");

        // Inverted waveform re-learns active-low
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 704; i++) rnd_px(1, 1, "pol_lo_line");
            for (int i = 0; i < 96; i++)  rnd_px(0, 1, "pol_lo_pulse");
        end
        for (int i = 0; i < 704; i++) rnd_px(1, 1, "pol_lo_line");
        for (int i = 0; i < 50; i++)  rnd_px(0, 1, "pol_lo_pulse");
        chk("hs_pol_lo", 32'(hs_pol), 32'd0);
        chk("vga_hs_pulse_lo", 32'(vga_hs), 32'd0);

        // Flat colours across several frames: dither pattern and no-wrap at full scale
        do_reset(1'b0);
        for (int fr = 0; fr < 3; fr++)
            for (int ln = 0; ln < 4; ln++)
                for (int c = 0; c < 8; c++)
                    px(8'h02, 8'h02, 8'h02, (c >= 2), (ln != 0), 0, "dither_02");
        for (int fr = 0; fr < 3; fr++)
            for (int ln = 0; ln < 4; ln++)
                for (int c = 0; c < 8; c++) begin
                    px(8'hFE, 8'hFE, 8'hFE, (c >= 2), (ln != 0), 0, "dither_fe");
                    if (fr > 0) chk("fe_nowrap", 32'(vga_g), 32'h3F);
                end

        // Blanking forces black while sync keeps flowing
        px(8'hFF, 8'hFF, 8'hFF, 1, 1, 1, "blank_ff");
        px(8'hFF, 8'hFF, 8'hFF, 0, 1, 1, "blank_ff");
        chk("blank_black", 32'(vga_b), 32'd0);
        px(8'hFF, 8'hFF, 8'hFF, 1, 1, 0, "blank_ff");

        // Random traffic, freeze, mid-line reset and resume
        do_reset(1'($urandom));
        for (int ln = 0; ln < 25; ln++)
            for (int c = 0; c < 16; c++)
                rnd_px((c >= 3), ((ln % 5) != 0), "rand");
        idle(10);
        for (int c = 0; c < 7; c++) rnd_px((c >= 3), 1, "rand_mid");
        do_reset(1'($urandom));
        for (int ln = 0; ln < 10; ln++)
            for (int c = 0; c < 16; c++)
                rnd_px((c >= 3), ((ln % 5) != 0), "rand_resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
